// File: rtl/cross_router_switch_allocator.sv
// Per-output round-robin switch allocator with burst lock; grant one cycle after valid, one idle cycle after last.
// Backpressure: owner's in_ready follows its output's ready combinationally, so the lock holds through stalls.
module cross_router_switch_allocator #(
   parameter int CHANNEL_NUMBER = 5,
   parameter int PTR_WIDTH      = $clog2(CHANNEL_NUMBER)
) (
   input  logic                                      clk_i,
   input  logic                                      rst_n_i,
   input  logic [CHANNEL_NUMBER-1:0]                 req_valid_i,
   input  logic [CHANNEL_NUMBER*CHANNEL_NUMBER-1:0]  req_route_i,
   input  logic [CHANNEL_NUMBER-1:0]                 req_last_i,
   input  logic [CHANNEL_NUMBER-1:0]                 out_ready_i,
   output logic [CHANNEL_NUMBER-1:0]                 in_ready_o,
   output logic [CHANNEL_NUMBER-1:0]                 out_valid_o,
   output logic [CHANNEL_NUMBER*CHANNEL_NUMBER-1:0]  grant_o,
   output logic [CHANNEL_NUMBER-1:0]                 busy_o
);

   localparam int N = CHANNEL_NUMBER;

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t               state_q  [N];
   state_t               state_d  [N];
   logic [PTR_WIDTH-1:0] winner_q [N];
   logic [PTR_WIDTH-1:0] winner_d [N];
   logic [PTR_WIDTH-1:0] rr_ptr_q [N];
   logic [PTR_WIDTH-1:0] rr_ptr_d [N];

   logic [N-1:0]         eff_route [N];
   logic [N-1:0]         cand      [N];
   logic [PTR_WIDTH-1:0] pick      [N];
   logic [N-1:0]         pick_vld;

   // Lowest set bit wins, so a malformed multi-hot route still targets one output only.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         eff_route[i] = req_route_i[i*N +: N] & (~req_route_i[i*N +: N] + N'(1));
      end
   end

   always_comb begin
      int idx;
      idx      = 0;
      pick_vld = '0;
      for (int o = 0; o < N; o++) begin
         cand[o] = '0;
         pick[o] = '0;
         for (int i = 0; i < N; i++) begin
            cand[o][i] = req_valid_i[i] & eff_route[i][o];
         end
         // Scan starts just past the last served input and wraps.
         for (int k = 1; k <= N; k++) begin
            idx = int'(rr_ptr_q[o]) + k;
            if (idx >= N) idx = idx - N;
            if (!pick_vld[o] && cand[o][idx]) begin
               pick_vld[o] = 1'b1;
               pick[o]     = PTR_WIDTH'(idx);
            end
         end
      end
   end

   always_comb begin
      grant_o     = '0;
      busy_o      = '0;
      out_valid_o = '0;
      in_ready_o  = '0;
      for (int o = 0; o < N; o++) begin
         state_d[o]  = state_q[o];
         winner_d[o] = winner_q[o];
         rr_ptr_d[o] = rr_ptr_q[o];
         case (state_q[o])
            IDLE: begin
               if (pick_vld[o]) begin
                  state_d[o]  = LOCKED;
                  winner_d[o] = pick[o];
               end
            end
            LOCKED: begin
               grant_o[o*N + int'(winner_q[o])] = 1'b1;
               busy_o[o]                        = 1'b1;
               out_valid_o[o]                   = req_valid_i[winner_q[o]];
               in_ready_o[winner_q[o]]          = in_ready_o[winner_q[o]] | out_ready_i[o];
               if (req_valid_i[winner_q[o]] && out_ready_i[o] && req_last_i[winner_q[o]]) begin
                  state_d[o]  = IDLE;
                  rr_ptr_d[o] = winner_q[o];
               end
            end
            default: state_d[o] = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int o = 0; o < N; o++) begin
            state_q[o]  <= IDLE;
            winner_q[o] <= '0;
            rr_ptr_q[o] <= PTR_WIDTH'(N-1);
         end
      end else begin
         for (int o = 0; o < N; o++) begin
            state_q[o]  <= state_d[o];
            winner_q[o] <= winner_d[o];
            rr_ptr_q[o] <= rr_ptr_d[o];
         end
      end
   end

endmodule

// File: tb/tb_cross_router_switch_allocator.sv
// Bench for cross_router_switch_allocator: vector table, hand sequences, randomized run against a queue-free owner/pointer model.
module tb_cross_router_switch_allocator;

   localparam int N = 5;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   valid, last, oready;
   logic [N*N-1:0] route;
   logic [N-1:0]   in_ready, out_valid, busy;
   logic [N*N-1:0] grant;

   int n_cmp = 0;
   int n_err = 0;
   int own [N];
   int ptr [N];

   typedef struct {
      logic [N-1:0]   v;
      logic [N*N-1:0] r;
      logic [N-1:0]   l;
      logic [N-1:0]   rdy;
      logic [N*N-1:0] g;
      logic [N-1:0]   b;
      logic [N-1:0]   ir;
      logic [N-1:0]   ov;
   } vec_t;

   vec_t tbl [$];

   always #5 clk = ~clk;

   cross_router_switch_allocator #(.CHANNEL_NUMBER(N)) dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .req_valid_i(valid), .req_route_i(route), .req_last_i(last), .out_ready_i(oready),
      .in_ready_o(in_ready), .out_valid_o(out_valid), .grant_o(grant), .busy_o(busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [N*N-1:0] rt(input int i, input int o);
      logic [N*N-1:0] v;
      v = '0;
      v[i*N + o] = 1'b1;
      return v;
   endfunction

   function automatic logic [N*N-1:0] gb(input int o, input int i);
      logic [N*N-1:0] v;
      v = '0;
      v[o*N + i] = 1'b1;
      return v;
   endfunction

   function automatic int low_bit(input logic [N-1:0] r);
      for (int j = 0; j < N; j++) if (r[j]) return j;
      return -1;
   endfunction

   task automatic model_reset();
      for (int o = 0; o < N; o++) begin
         own[o] = -1;
         ptr[o] = N - 1;
      end
   endtask

   task automatic model_clock();
      int w;
      int c;
      for (int o = 0; o < N; o++) begin
         if (own[o] < 0) begin
            for (int k = 1; k <= N; k++) begin
               c = (ptr[o] + k) % N;
               if (own[o] < 0 && valid[c] && low_bit(route[c*N +: N]) == o) own[o] = c;
            end
         end else begin
            w = own[o];
            if (valid[w] && oready[o] && last[w]) begin
               own[o] = -1;
               ptr[o] = w;
            end
         end
      end
   endtask

   task automatic drive(input logic [N-1:0] v, input logic [N*N-1:0] r,
                        input logic [N-1:0] l, input logic [N-1:0] rdy);
      valid = v; route = r; last = l; oready = rdy;
   endtask

   task automatic tick();
      if (rst_n) model_clock();
      else       model_reset();
      @(posedge clk);
      #1;
   endtask

   task automatic check_now(input string tag, input logic [N*N-1:0] g, input logic [N-1:0] b,
                            input logic [N-1:0] ir, input logic [N-1:0] ov);
      chk({tag, " grant"},     32'(grant),     32'(g));
      chk({tag, " busy"},      32'(busy),      32'(b));
      chk({tag, " in_ready"},  32'(in_ready),  32'(ir));
      chk({tag, " out_valid"}, 32'(out_valid), 32'(ov));
   endtask

   task automatic check_model(input string tag);
      logic [N*N-1:0] g;
      logic [N-1:0]   b, ir, ov;
      g = '0; b = '0; ir = '0; ov = '0;
      for (int o = 0; o < N; o++) begin
         if (own[o] >= 0) begin
            g[o*N + own[o]] = 1'b1;
            b[o]            = 1'b1;
            ov[o]           = valid[own[o]];
            if (oready[o]) ir[own[o]] = 1'b1;
         end
      end
      check_now(tag, g, b, ir, ov);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      for (int k = 0; k < 3; k++) begin
         drive(N'($urandom), N*N'({$urandom, $urandom}), N'($urandom), N'($urandom));
         @(negedge clk);
         check_now($sformatf("reset%0d", k), '0, '0, '0, '0);
         @(posedge clk);
         #1;
      end
      drive('0, '0, '0, '0);
      rst_n = 1'b1;
   endtask

   logic [N*N-1:0] r2, r3, r4;
   logic [N-1:0]   cur_route [N];
   bit             taken;

   initial begin
      drive('0, '0, '0, '0);
      model_reset();
      #1;

      r2 = rt(1, 2);
      r3 = rt(0, 4) | rt(1, 4) | rt(3, 4);
      // input 1 -> output 2, three beats
      tbl.push_back('{5'b00010, r2, 5'b00000, 5'b00100, '0,        5'b00000, 5'b00000, 5'b00000});
      tbl.push_back('{5'b00010, r2, 5'b00000, 5'b00100, gb(2, 1), 5'b00100, 5'b00010, 5'b00100});
      tbl.push_back('{5'b00010, r2, 5'b00000, 5'b00100, gb(2, 1), 5'b00100, 5'b00010, 5'b00100});
      tbl.push_back('{5'b00010, r2, 5'b00010, 5'b00100, gb(2, 1), 5'b00100, 5'b00010, 5'b00100});
      tbl.push_back('{5'b00000, r2, 5'b00000, 5'b00100, '0,        5'b00000, 5'b00000, 5'b00000});
      // inputs 0,1,3 -> output 4, single beats; then 0 and 3 again
      tbl.push_back('{5'b01011, r3, 5'b01011, 5'b10000, '0,        5'b00000, 5'b00000, 5'b00000});
      tbl.push_back('{5'b01011, r3, 5'b01011, 5'b10000, gb(4, 0), 5'b10000, 5'b00001, 5'b10000});
      tbl.push_back('{5'b01010, r3, 5'b01011, 5'b10000, '0,        5'b00000, 5'b00000, 5'b00000});
      tbl.push_back('{5'b01010, r3, 5'b01011, 5'b10000, gb(4, 1), 5'b10000, 5'b00010, 5'b10000});
      tbl.push_back('{5'b01000, r3, 5'b01011, 5'b10000, '0,        5'b00000, 5'b00000, 5'b00000});
      tbl.push_back('{5'b01000, r3, 5'b01011, 5'b10000, gb(4, 3), 5'b10000, 5'b01000, 5'b10000});
      tbl.push_back('{5'b01001, r3, 5'b01011, 5'b10000, '0,        5'b00000, 5'b00000, 5'b00000});
      tbl.push_back('{5'b01001, r3, 5'b01011, 5'b10000, gb(4, 0), 5'b10000, 5'b00001, 5'b10000});
      tbl.push_back('{5'b00000, r3, 5'b00000, 5'b10000, '0,        5'b00000, 5'b00000, 5'b00000});

      do_reset();
      foreach (tbl[k]) begin
         drive(tbl[k].v, tbl[k].r, tbl[k].l, tbl[k].rdy);
         @(negedge clk);
         check_now($sformatf("vec%0d", k), tbl[k].g, tbl[k].b, tbl[k].ir, tbl[k].ov);
         tick();
      end

      // stall mid-burst with a competing requester
      do_reset();
      r4 = rt(0, 1) | rt(2, 1);
      drive(5'b00001, rt(0, 1), 5'b00000, 5'b00010);
      @(negedge clk); chk("stall idle busy", 32'(busy), 32'(0));
      tick();
      @(negedge clk); check_now("stall beat1", gb(1, 0), 5'b00010, 5'b00001, 5'b00010);
      tick();
      drive(5'b00101, r4, 5'b00000, 5'b00000);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check_now($sformatf("stall%0d", k), gb(1, 0), 5'b00010, 5'b00000, 5'b00010);
         tick();
      end
      drive(5'b00101, r4, 5'b00001, 5'b00010);
      @(negedge clk); check_now("stall resume", gb(1, 0), 5'b00010, 5'b00001, 5'b00010);
      tick();
      drive(5'b00100, rt(2, 1), 5'b00000, 5'b00010);
      @(negedge clk); chk("stall gap busy", 32'(busy), 32'(0));
      tick();
      @(negedge clk); check_now("stall next", gb(1, 2), 5'b00010, 5'b00100, 5'b00010);
      tick();

      // two outputs granted in the same cycle
      do_reset();
      drive(5'b00011, rt(0, 2) | rt(1, 3), 5'b00011, 5'b11111);
      @(negedge clk); chk("conc idle busy", 32'(busy), 32'(0));
      tick();
      @(negedge clk); check_now("conc", gb(2, 0) | gb(3, 1), 5'b01100, 5'b00011, 5'b01100);
      tick();

      // asynchronous reset mid-burst, then pointer back at N-1
      do_reset();
      drive(5'b00001, rt(0, 0), 5'b00001, 5'b00001);
      tick();
      @(negedge clk); chk("ar first grant", 32'(grant), 32'(gb(0, 0)));
      tick();
      drive(5'b01000, rt(3, 0), 5'b00000, 5'b00001);
      @(negedge clk); chk("ar gap busy", 32'(busy), 32'(0));
      tick();
      @(negedge clk); chk("ar burst grant", 32'(grant), 32'(gb(0, 3)));
      tick();
      #2 rst_n = 1'b0;
      #1 check_now("ar async", '0, '0, '0, '0);
      model_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
      drive(5'b00101, rt(0, 0) | rt(2, 0), 5'b00101, 5'b00001);
      @(negedge clk); chk("ar post idle busy", 32'(busy), 32'(0));
      tick();
      @(negedge clk); chk("ar post grant", 32'(grant), 32'(gb(0, 0)));
      tick();

      // randomized traffic against the model; routes only change while the input is unowned
      do_reset();
      for (int i = 0; i < N; i++) cur_route[i] = '0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         for (int i = 0; i < N; i++) begin
            taken = 1'b0;
            for (int o = 0; o < N; o++) if (own[o] == i) taken = 1'b1;
            if (!taken && $urandom_range(0, 3) == 0) begin
               case ($urandom_range(0, 9))
                  0:       cur_route[i] = '0;
                  1:       cur_route[i] = N'($urandom_range(0, 31));
                  default: cur_route[i] = N'(1) << $urandom_range(0, N-1);
               endcase
            end
            route[i*N +: N] = cur_route[i];
            valid[i] = ($urandom_range(0, 9) < 7);
            last[i]  = ($urandom_range(0, 9) < 3);
         end
         oready = N'($urandom);
         @(negedge clk);
         check_model($sformatf("rand%0d", cyc));
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
